// File: rtl/im_rr_arbiter_if.sv
// Bundle between the instruction-memory arbiter and its surroundings (cores + RAM).
//   en, req, addr_in : per-core enable, level fetch request, packed fetch addresses
//   gnt, rvalid      : one-hot grant of the fetch in flight, one-cycle completion pulse
//   rdata            : fetched instruction, shared by all cores
//   mem_addr, mem_rd : read address/strobe to the instruction RAM
//   mem_rdata        : RAM read data
//   busy             : arbiter is not idle
// slave  : the arbiter side.
// master : the cores + RAM side.
interface im_rr_arbiter_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned AW    = 16,
  parameter int unsigned DW    = 16
) ();

  logic [N_REQ-1:0]    en;
  logic [N_REQ-1:0]    req;
  logic [N_REQ*AW-1:0] addr_in;
  logic [N_REQ-1:0]    gnt;
  logic [N_REQ-1:0]    rvalid;
  logic [DW-1:0]       rdata;
  logic [AW-1:0]       mem_addr;
  logic                mem_rd;
  logic [DW-1:0]       mem_rdata;
  logic                busy;

  modport slave (
    input  en, req, addr_in, mem_rdata,
    output gnt, rvalid, rdata, mem_addr, mem_rd, busy
  );

  modport master (
    output en, req, addr_in, mem_rdata,
    input  gnt, rvalid, rdata, mem_addr, mem_rd, busy
  );

endinterface

// File: rtl/im_rr_arbiter.sv
// Round-robin arbiter sharing one instruction RAM between N_REQ cores.
// One fetch at a time: IDLE picks a winner, ISSUE strobes the RAM, WAIT covers the
// remaining read latency, DONE captures the data; rvalid pulses in the following IDLE.
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : im_rr_arbiter_if.slave (request/grant/data and RAM signals)
// All outputs are registered.
module im_rr_arbiter #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned AW     = 16,
  parameter int unsigned DW     = 16,
  parameter int unsigned RD_LAT = 1
) (
  input  logic           clk,
  input  logic           rst,
  im_rr_arbiter_if.slave bus
);

  localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CW = 3;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e           state_q;
  logic [N_REQ-1:0] gnt_q;
  logic [N_REQ-1:0] rvalid_q;
  logic [DW-1:0]    rdata_q;
  logic [AW-1:0]    mem_addr_q;
  logic             mem_rd_q;
  logic             busy_q;
  logic [PW-1:0]    ptr_q;
  logic [PW-1:0]    win_q;
  logic [CW-1:0]    cnt_q;

  logic [N_REQ-1:0] eligible;
  logic             found;
  logic [PW-1:0]    win_idx;
  int unsigned      idx;

  // A core whose rvalid is high this cycle may still show a stale req; mask it out.
  assign eligible = bus.req & bus.en & ~rvalid_q;

  // First eligible index scanning upward from ptr+1 with wrap-around.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    idx     = 0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx = (32'(ptr_q) + k) % N_REQ;
      if (!found && eligible[PW'(idx)]) begin
        found   = 1'b1;
        win_idx = PW'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      gnt_q      <= '0;
      rvalid_q   <= '0;
      rdata_q    <= '0;
      mem_addr_q <= '0;
      mem_rd_q   <= 1'b0;
      busy_q     <= 1'b0;
      cnt_q      <= '0;
      ptr_q      <= PW'(N_REQ - 1);
      win_q      <= '0;
    end else begin
      rvalid_q <= '0;
      mem_rd_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (found) begin
            state_q    <= StIssue;
            win_q      <= win_idx;
            gnt_q      <= N_REQ'(1) << win_idx;
            mem_addr_q <= bus.addr_in[win_idx*AW +: AW];
            mem_rd_q   <= 1'b1;
            busy_q     <= 1'b1;
            cnt_q      <= CW'(RD_LAT - 1);
          end
        end
        StIssue: begin
          state_q <= (RD_LAT > 1) ? StWait : StDone;
        end
        StWait: begin
          if (cnt_q <= CW'(1)) begin
            state_q <= StDone;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        StDone: begin
          state_q    <= StIdle;
          rdata_q    <= bus.mem_rdata;
          rvalid_q   <= gnt_q;
          ptr_q      <= win_q;
          gnt_q      <= '0;
          mem_addr_q <= '0;
          busy_q     <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.rvalid   = rvalid_q;
  assign bus.rdata    = rdata_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_rd   = mem_rd_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_im_rr_arbiter.sv
// Bench for im_rr_arbiter: four instances (RD_LAT 1..4) share the same core-side
// stimulus; each has its own RAM model returning addr ^ 16'hABDF exactly RD_LAT
// cycles after the read strobe and 16'hDEAD otherwise.
module tb_im_rr_arbiter;

  localparam logic [15:0] A0 = 16'h1000, A1 = 16'h2101, A2 = 16'h0012, A3 = 16'h3303;
  localparam logic [15:0] D0 = 16'hBBDF, D1 = 16'h8ADE, D2 = 16'hABCD, D3 = 16'h98DC;

  logic        clk;
  logic        rst;
  logic [3:0]  en;
  logic [3:0]  req;
  logic [63:0] addr_in;

  logic [3:0]  gnt_a      [4];
  logic [3:0]  rvalid_a   [4];
  logic [15:0] rdata_a    [4];
  logic [15:0] mem_addr_a [4];
  logic        mem_rd_a   [4];
  logic        busy_a     [4];

  int checks;
  int errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_lat
    im_rr_arbiter_if #(.N_REQ(4), .AW(16), .DW(16)) bus ();
    logic [15:0] pipe_d [4];
    logic        pipe_v [4];

    assign bus.en        = en;
    assign bus.req       = req;
    assign bus.addr_in   = addr_in;
    assign bus.mem_rdata = pipe_v[g] ? pipe_d[g] : 16'hDEAD;

    always_ff @(posedge clk) begin
      pipe_v[0] <= bus.mem_rd;
      pipe_d[0] <= bus.mem_addr ^ 16'hABDF;
      for (int i = 1; i < 4; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_d[i] <= pipe_d[i-1];
      end
    end

    im_rr_arbiter #(.N_REQ(4), .AW(16), .DW(16), .RD_LAT(g + 1)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
    );

    assign gnt_a[g]      = bus.gnt;
    assign rvalid_a[g]   = bus.rvalid;
    assign rdata_a[g]    = bus.rdata;
    assign mem_addr_a[g] = bus.mem_addr;
    assign mem_rd_a[g]   = bus.mem_rd;
    assign busy_a[g]     = bus.busy;
  end

  typedef struct {
    logic        chk;
    logic        rst;
    logic [3:0]  en;
    logic [3:0]  req;
    logic [3:0]  gnt;
    logic [3:0]  rvalid;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic        busy;
    logic [15:0] rdata;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic c, input logic r, input logic [3:0] e, input logic [3:0] q,
                     input logic [3:0] g, input logic [3:0] v, input logic rd,
                     input logic [15:0] a, input logic b, input logic [15:0] d);
    vec_t x;
    x.chk = c; x.rst = r; x.en = e; x.req = q; x.gnt = g; x.rvalid = v;
    x.mem_rd = rd; x.mem_addr = a; x.busy = b; x.rdata = d;
    vecs.push_back(x);
  endtask

  task automatic check(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (%0d): got %h, want %h", name, row, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = 4'h0;
    en  = 4'hF;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_rv [4];
    logic [3:0]  rv_val [4];
    logic [15:0] rd_val [4];
    int rd_cnt [4];
    int rv_seen;

    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    en      = 4'hF;
    req     = 4'h0;
    addr_in = {A3, A2, A1, A0};

    // Rows: inputs applied this cycle, outputs expected this cycle (RD_LAT=1 instance).
    //  chk rst en    req     gnt     rvalid  rd  addr  busy rdata
    add(0, 1, 4'hF, 4'h0,   4'h0,   4'h0,   0,  0,    0,   0);
    add(1, 0, 4'hF, 4'h0,   4'h0,   4'h0,   0,  0,    0,   0);   // reset state
    // single fetch by core 2
    add(1, 0, 4'hF, 4'h4,   4'h0,   4'h0,   0,  0,    0,   0);
    add(1, 0, 4'hF, 4'h4,   4'h4,   4'h0,   1,  A2,   1,   0);
    add(1, 0, 4'hF, 4'h4,   4'h4,   4'h0,   0,  A2,   1,   0);
    add(1, 0, 4'hF, 4'h0,   4'h0,   4'h4,   0,  0,    0,   D2);
    add(1, 0, 4'hF, 4'h0,   4'h0,   4'h0,   0,  0,    0,   D2);
    // stale req from core 1 in its rvalid cycle, then a genuine re-request
    add(1, 0, 4'hF, 4'h2,   4'h0,   4'h0,   0,  0,    0,   D2);
    add(1, 0, 4'hF, 4'h2,   4'h2,   4'h0,   1,  A1,   1,   D2);
    add(1, 0, 4'hF, 4'h2,   4'h2,   4'h0,   0,  A1,   1,   D2);
    add(1, 0, 4'hF, 4'h2,   4'h0,   4'h2,   0,  0,    0,   D1);
    add(1, 0, 4'hF, 4'h2,   4'h0,   4'h0,   0,  0,    0,   D1);
    add(1, 0, 4'hF, 4'h0,   4'h2,   4'h0,   1,  A1,   1,   D1);  // req dropped mid-fetch
    add(1, 0, 4'hF, 4'h0,   4'h2,   4'h0,   0,  A1,   1,   D1);
    add(1, 0, 4'hF, 4'h0,   4'h0,   4'h2,   0,  0,    0,   D1);
    add(1, 0, 4'hF, 4'h0,   4'h0,   4'h0,   0,  0,    0,   D1);
    // reset, then all four request: order 0,1,2,3,0
    add(1, 1, 4'hF, 4'h0,   4'h0,   4'h0,   0,  0,    0,   D1);
    add(1, 0, 4'hF, 4'hF,   4'h0,   4'h0,   0,  0,    0,   0);
    add(1, 0, 4'hF, 4'hF,   4'h1,   4'h0,   1,  A0,   1,   0);
    add(1, 0, 4'hF, 4'hF,   4'h1,   4'h0,   0,  A0,   1,   0);
    add(1, 0, 4'hF, 4'hF,   4'h0,   4'h1,   0,  0,    0,   D0);
    add(1, 0, 4'hF, 4'hF,   4'h2,   4'h0,   1,  A1,   1,   D0);
    add(1, 0, 4'hF, 4'hF,   4'h2,   4'h0,   0,  A1,   1,   D0);
    add(1, 0, 4'hF, 4'hF,   4'h0,   4'h2,   0,  0,    0,   D1);
    add(1, 0, 4'hF, 4'hF,   4'h4,   4'h0,   1,  A2,   1,   D1);
    add(1, 0, 4'hF, 4'hF,   4'h4,   4'h0,   0,  A2,   1,   D1);
    add(1, 0, 4'hF, 4'hF,   4'h0,   4'h4,   0,  0,    0,   D2);
    add(1, 0, 4'hF, 4'hF,   4'h8,   4'h0,   1,  A3,   1,   D2);
    add(1, 0, 4'hF, 4'hF,   4'h8,   4'h0,   0,  A3,   1,   D2);
    add(1, 0, 4'hF, 4'hF,   4'h0,   4'h8,   0,  0,    0,   D3);
    add(1, 0, 4'hF, 4'h0,   4'h1,   4'h0,   1,  A0,   1,   D3);
    add(1, 0, 4'hF, 4'h0,   4'h1,   4'h0,   0,  A0,   1,   D3);
    add(1, 0, 4'hF, 4'h0,   4'h0,   4'h1,   0,  0,    0,   D0);
    add(1, 0, 4'hF, 4'h0,   4'h0,   4'h0,   0,  0,    0,   D0);
    // enable mask 0011: cores 1,0,1 alternate; en dropped during the last fetch
    add(1, 0, 4'h3, 4'hF,   4'h0,   4'h0,   0,  0,    0,   D0);
    add(1, 0, 4'h3, 4'hF,   4'h2,   4'h0,   1,  A1,   1,   D0);
    add(1, 0, 4'h3, 4'hF,   4'h2,   4'h0,   0,  A1,   1,   D0);
    add(1, 0, 4'h3, 4'hF,   4'h0,   4'h2,   0,  0,    0,   D1);
    add(1, 0, 4'h3, 4'hF,   4'h1,   4'h0,   1,  A0,   1,   D1);
    add(1, 0, 4'h3, 4'hF,   4'h1,   4'h0,   0,  A0,   1,   D1);
    add(1, 0, 4'h3, 4'hF,   4'h0,   4'h1,   0,  0,    0,   D0);
    add(1, 0, 4'h3, 4'hF,   4'h2,   4'h0,   1,  A1,   1,   D0);
    add(1, 0, 4'h0, 4'hF,   4'h2,   4'h0,   0,  A1,   1,   D0);
    add(1, 0, 4'h0, 4'hF,   4'h0,   4'h2,   0,  0,    0,   D1);
    add(1, 0, 4'h0, 4'hF,   4'h0,   4'h0,   0,  0,    0,   D1);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst = vecs[i].rst;
      en  = vecs[i].en;
      req = vecs[i].req;
      if (vecs[i].chk) begin
        check("gnt",      i, gnt_a[0],      vecs[i].gnt);
        check("rvalid",   i, rvalid_a[0],   vecs[i].rvalid);
        check("mem_rd",   i, mem_rd_a[0],   vecs[i].mem_rd);
        check("mem_addr", i, mem_addr_a[0], vecs[i].mem_addr);
        check("busy",     i, busy_a[0],     vecs[i].busy);
        check("rdata",    i, rdata_a[0],    vecs[i].rdata);
      end
    end

    // Latency sweep: core 2 requests in IDLE cycle 0 on all four instances.
    do_reset();
    req = 4'h4;
    for (int g = 0; g < 4; g++) begin
      first_rv[g] = -1;
      rv_val[g]   = '0;
      rd_val[g]   = '0;
      rd_cnt[g]   = 0;
    end
    for (int n = 0; n < 10; n++) begin
      if (n > 0) @(negedge clk);
      if (n == 1) req = 4'h0;
      for (int g = 0; g < 4; g++) begin
        if (rvalid_a[g] != 4'h0 && first_rv[g] < 0) begin
          first_rv[g] = n;
          rv_val[g]   = rvalid_a[g];
          rd_val[g]   = rdata_a[g];
        end
        if (mem_rd_a[g]) rd_cnt[g]++;
      end
    end
    for (int g = 0; g < 4; g++) begin
      check("lat_rvalid_cycle", g + 1, first_rv[g], 32'(g + 3));
      check("lat_mem_rd_count", g + 1, rd_cnt[g],   32'd1);
      check("lat_rvalid_bits",  g + 1, rv_val[g],   4'h4);
      check("lat_rdata",        g + 1, rd_val[g],   D2);
    end

    // Reset during WAIT (RD_LAT=3 instance): abort, then core 0 wins first.
    do_reset();
    req = 4'h4;                       // cycle 0
    @(negedge clk);                   // cycle 1: ISSUE
    @(negedge clk);                   // cycle 2: WAIT
    check("rst_wait_busy",   2, busy_a[2],     1'b1);
    check("rst_wait_gnt",    2, gnt_a[2],      4'h4);
    check("rst_wait_mem_rd", 2, mem_rd_a[2],   1'b0);
    check("rst_wait_addr",   2, mem_addr_a[2], A2);
    rst = 1'b1;
    @(negedge clk);                   // cycle 3: reset state
    rst = 1'b0;
    req = 4'hF;
    check("rst_gnt",      3, gnt_a[2],      4'h0);
    check("rst_rvalid",   3, rvalid_a[2],   4'h0);
    check("rst_mem_rd",   3, mem_rd_a[2],   1'b0);
    check("rst_mem_addr", 3, mem_addr_a[2], 16'h0);
    check("rst_busy",     3, busy_a[2],     1'b0);
    check("rst_rdata",    3, rdata_a[2],    16'h0);
    rv_seen = 0;
    @(negedge clk);                   // cycle 4: ISSUE for core 0
    req = 4'h0;
    check("rst_regrant_gnt",  4, gnt_a[2],      4'h1);
    check("rst_regrant_rd",   4, mem_rd_a[2],   1'b1);
    check("rst_regrant_addr", 4, mem_addr_a[2], A0);
    for (int n = 4; n < 8; n++) begin
      if (n > 4) @(negedge clk);
      if (rvalid_a[2] != 4'h0) rv_seen++;
    end
    check("rst_no_rvalid", 7, rv_seen, 32'd0);
    @(negedge clk);                   // cycle 8: rvalid for core 0
    check("rst_next_rvalid", 8, rvalid_a[2], 4'h1);
    check("rst_next_rdata",  8, rdata_a[2],  D0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
